// File: rtl/debug_bridge_pkg.sv
// ---------------------------------------------------------------------------
// debug_bridge_pkg
// Shared definitions for the debug command bridge:
//   - bridge_state_e : command-holding FSM states (IDLE, PEND)
//   - SR_W_DEF/IR_W_DEF : default shift-register and instruction widths
//   - onehot()       : decodes an instruction code into a one-hot vector
// ---------------------------------------------------------------------------
package debug_bridge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } bridge_state_e;

    localparam int SR_W_DEF = 38;
    localparam int IR_W_DEF = 2;

    // onehot() works on a fixed maximum code width so a single function
    // serves every IR_W instance; callers cast the result to their NUM_CMD.
    localparam int MAX_IR_W     = 8;
    localparam int ONEHOT_MAX_W = 1 << MAX_IR_W;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [MAX_IR_W-1:0] code);
        logic [ONEHOT_MAX_W-1:0] vec;
        vec       = '0;
        vec[code] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/debug_cmd_sync_bridge_sync.sv
// ---------------------------------------------------------------------------
// debug_sync_edge
// Brings an asynchronous level into clk through a STAGES-deep flop chain and
// emits a registered one-cycle pulse on each rising edge of the synchronised
// level.
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   async_i : level from the foreign (tck) domain
//   rise_o  : one-cycle pulse, high the cycle after a rise is seen
// ---------------------------------------------------------------------------
module debug_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    localparam int                GATE_W    = $clog2(STAGES + 2);
    localparam logic [GATE_W-1:0] GATE_DONE = GATE_W'(STAGES + 1);

    logic [STAGES-1:0] sync_q;
    logic              last_dly_q;
    logic              rise_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic              gate_open;

    // The chain restarts from zero on reset, so a level that stayed high
    // across reset would look like a fresh rise once it refills the chain.
    // Edge detection stays closed until the chain and its delayed copy
    // have caught up with the input.
    assign gate_open = (gate_cnt_q == GATE_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            last_dly_q <= 1'b0;
            rise_q     <= 1'b0;
            gate_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[STAGES-2:0], async_i};
            last_dly_q <= sync_q[STAGES-1];
            rise_q     <= gate_open & sync_q[STAGES-1] & ~last_dly_q;
            if (!gate_open) begin
                gate_cnt_q <= gate_cnt_q + GATE_W'(1);
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/debug_cmd_sync_bridge.sv
// ---------------------------------------------------------------------------
// debug_cmd_sync_bridge
// System-clock side of the CPU debug slave. Synchronises the virtual-JTAG
// update-IR / update-DR strobes, captures the shift register, holds one
// command behind a valid/ready handshake and turns each accepted command
// into a one-cycle one-hot action pulse. Commands arriving while one is
// still pending are dropped and counted.
// Ports:
//   clk, reset      : system clock, asynchronous active-high reset
//   vs_uir, vs_udr  : tck-domain update-IR / update-DR levels
//   ir_in, sr       : instruction and shift register from the tck domain
//   cmd_ready       : consumer accepts the pending command
//   clr_overrun     : clears overrun and dropped_count
//   jdo, cmd_code   : captured data and instruction of the pending command
//   cmd_valid       : a command is pending
//   take_action     : one-hot pulse, executed command with action bit set
//   take_no_action  : one-hot pulse, executed command with action bit clear
//   overrun         : sticky flag, a command was dropped
//   dropped_count   : saturating count of dropped commands
// ---------------------------------------------------------------------------
module debug_cmd_sync_bridge
    import debug_bridge_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vs_uir,
    input  logic                  vs_udr,
    input  logic [IR_W-1:0]       ir_in,
    input  logic [SR_W-1:0]       sr,
    input  logic                  cmd_ready,
    input  logic                  clr_overrun,
    output logic [SR_W-1:0]       jdo,
    output logic                  cmd_valid,
    output logic [IR_W-1:0]       cmd_code,
    output logic [(2**IR_W)-1:0]  take_action,
    output logic [(2**IR_W)-1:0]  take_no_action,
    output logic                  overrun,
    output logic [CNT_W-1:0]      dropped_count
);

    localparam int               NUM_CMD = 2 ** IR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic uir_rise;
    logic udr_rise;

    bridge_state_e state_q, state_d;

    logic [IR_W-1:0]    ir_q;
    logic [IR_W-1:0]    new_code;
    logic [SR_W-1:0]    jdo_q;
    logic [IR_W-1:0]    cmd_code_q;
    logic               act_q;
    logic [NUM_CMD-1:0] take_action_q;
    logic [NUM_CMD-1:0] take_no_action_q;
    logic [NUM_CMD-1:0] code_onehot;
    logic               overrun_q;
    logic [CNT_W-1:0]   dropped_count_q;

    logic handshake;
    logic accept;
    logic drop;
    logic pend;

    debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset   (reset),
        .async_i (vs_uir),
        .rise_o  (uir_rise)
    );

    debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset   (reset),
        .async_i (vs_udr),
        .rise_o  (udr_rise)
    );

    // When update-IR and update-DR land together the command must carry
    // the instruction that is arriving now, not the stale one in ir_q.
    assign new_code    = uir_rise ? ir_in : ir_q;
    assign code_onehot = NUM_CMD'(onehot(MAX_IR_W'(cmd_code_q)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new update-DR is taken when nothing is pending or when the pending
    // command is being handed off in the same cycle; otherwise it is dropped.
    always_comb begin
        state_d   = state_q;
        pend      = 1'b0;
        handshake = 1'b0;
        accept    = 1'b0;
        drop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (udr_rise) begin
                    accept  = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                pend      = 1'b1;
                handshake = cmd_ready;
                if (cmd_ready) begin
                    if (udr_rise) begin
                        accept = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (udr_rise) begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Instruction tracking and command capture. Pulses use the command
    // being handed off, which the NBA ordering keeps separate from any
    // command loaded on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q             <= '0;
            jdo_q            <= '0;
            cmd_code_q       <= '0;
            act_q            <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
        end else begin
            if (uir_rise) begin
                ir_q <= ir_in;
            end
            if (accept) begin
                jdo_q      <= sr;
                cmd_code_q <= new_code;
                act_q      <= sr[SR_W-1];
            end
            take_action_q    <= (handshake &&  act_q) ? code_onehot : '0;
            take_no_action_q <= (handshake && !act_q) ? code_onehot : '0;
        end
    end

    // Overrun bookkeeping; a clear coinciding with a drop leaves zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q       <= 1'b0;
            dropped_count_q <= '0;
        end else if (clr_overrun) begin
            overrun_q       <= 1'b0;
            dropped_count_q <= '0;
        end else if (drop) begin
            overrun_q <= 1'b1;
            if (dropped_count_q != CNT_MAX) begin
                dropped_count_q <= dropped_count_q + CNT_W'(1);
            end
        end
    end

    assign jdo            = jdo_q;
    assign cmd_valid      = pend;
    assign cmd_code       = cmd_code_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign overrun        = overrun_q;
    assign dropped_count  = dropped_count_q;

endmodule
